// File: rtl/i2s_pkg.sv
// Shared channel type, default geometry and helpers for the I2S stereo receiver.
package i2s_pkg;

    typedef enum logic {CH_LEFT = 1'b0, CH_RIGHT = 1'b1} i2s_ch_e;

    localparam int I2S_DATA_SIZE = 24;
    localparam int I2S_SLOT_SIZE = 32;
    localparam int OVERRUN_CNT_W = 16;

    function automatic logic [OVERRUN_CNT_W-1:0] sat_inc(input logic [OVERRUN_CNT_W-1:0] value);
        logic [OVERRUN_CNT_W-1:0] result;
        result = (value == {OVERRUN_CNT_W{1'b1}}) ? value : value + OVERRUN_CNT_W'(1);
        return result;
    endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// I2S master clocking: divides clk into SCK, tracks the slot bit position and WS.
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int SLOT_SIZE = I2S_SLOT_SIZE
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    output logic                         sck,
    output i2s_ch_e                      ws,
    output logic                         sck_rise,
    output logic                         sck_fall,
    output logic [$clog2(SLOT_SIZE)-1:0] pos
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int POS_W = $clog2(SLOT_SIZE);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(SLOT_SIZE - 1);

    logic [DIV_W-1:0] div_cnt_r;
    logic             sck_r;
    logic             sck_rise_r;
    logic             sck_fall_r;
    logic [POS_W-1:0] pos_r;
    i2s_ch_e          ws_r;

    // Divider, SCK toggle with same-cycle edge strobes, slot position and word select
    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            div_cnt_r  <= DIV_W'(0);
            sck_r      <= 1'b0;
            sck_rise_r <= 1'b0;
            sck_fall_r <= 1'b0;
            pos_r      <= POS_W'(0);
            ws_r       <= CH_LEFT;
        end else begin
            sck_rise_r <= 1'b0;
            sck_fall_r <= 1'b0;
            if (div_cnt_r == DIV_LAST) begin
                div_cnt_r <= DIV_W'(0);
                sck_r     <= ~sck_r;
                if (!sck_r) begin
                    sck_rise_r <= 1'b1;
                end else begin
                    // WS and position move on the falling edge so data is stable at the next rise
                    sck_fall_r <= 1'b1;
                    if (pos_r == POS_LAST) begin
                        pos_r <= POS_W'(0);
                        ws_r  <= (ws_r == CH_LEFT) ? CH_RIGHT : CH_LEFT;
                    end else begin
                        pos_r <= pos_r + POS_W'(1);
                    end
                end
            end else begin
                div_cnt_r <= div_cnt_r + DIV_W'(1);
            end
        end
    end

    assign sck      = sck_r;
    assign ws       = ws_r;
    assign sck_rise = sck_rise_r;
    assign sck_fall = sck_fall_r;
    assign pos      = pos_r;

endmodule

// File: rtl/i2s_rx_stereo.sv
// Stereo I2S master receiver with valid/ready pair output and sticky overrun.
// Define I2S_RX_OVERRUN_CNT_EN to add the saturating overrun_count output.
module i2s_rx_stereo
    import i2s_pkg::*;
#(
    parameter int DATA_SIZE = I2S_DATA_SIZE,
    parameter int SLOT_SIZE = I2S_SLOT_SIZE,
    parameter int CLK_DIV   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     i2s_sd,
    output logic                     i2s_sck,
    output logic                     i2s_ws,
    output logic [DATA_SIZE-1:0]     left_data,
    output logic [DATA_SIZE-1:0]     right_data,
    output logic                     frame_valid,
    input  logic                     frame_ready,
    output logic                     overrun,
`ifdef I2S_RX_OVERRUN_CNT_EN
    output logic [OVERRUN_CNT_W-1:0] overrun_count,
`endif
    input  logic                     overrun_clr
);

    localparam int POS_W = $clog2(SLOT_SIZE);
    localparam logic [POS_W-1:0] POS_FIRST = POS_W'(1);
    localparam logic [POS_W-1:0] POS_LAST  = POS_W'(DATA_SIZE);

    logic                 sck_s;
    i2s_ch_e              ws_s;
    logic                 sck_rise_s;
    logic                 sck_fall_s;
    logic [POS_W-1:0]     pos_s;

    logic [DATA_SIZE-1:0] left_sh_r;
    logic [DATA_SIZE-1:0] right_sh_r;
    logic [DATA_SIZE-1:0] left_next_s;
    logic [DATA_SIZE-1:0] right_next_s;
    logic [DATA_SIZE-1:0] left_data_r;
    logic [DATA_SIZE-1:0] right_data_r;
    logic                 frame_valid_r;
    logic                 overrun_r;

    logic                 cap_s;
    logic                 done_s;
    logic                 slot_start_s;
    logic                 accept_s;
    logic                 drop_s;

    i2s_clkgen #(
        .CLK_DIV   (CLK_DIV),
        .SLOT_SIZE (SLOT_SIZE)
    ) u_clkgen (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .sck      (sck_s),
        .ws       (ws_s),
        .sck_rise (sck_rise_s),
        .sck_fall (sck_fall_s),
        .pos      (pos_s)
    );

    // Capture window, pair completion and handshake decisions
    always_comb begin
        left_next_s  = DATA_SIZE'({left_sh_r, i2s_sd});
        right_next_s = DATA_SIZE'({right_sh_r, i2s_sd});
        cap_s        = enable && sck_rise_s && (pos_s >= POS_FIRST) && (pos_s <= POS_LAST);
        done_s       = cap_s && (ws_s == CH_RIGHT) && (pos_s == POS_LAST);
        slot_start_s = enable && sck_fall_s && (pos_s == POS_W'(0));
        accept_s     = !frame_valid_r || frame_ready;
        drop_s       = done_s && !accept_s;
    end

    // Per-channel MSB-first shift registers, restarted at each slot boundary
    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            left_sh_r  <= {DATA_SIZE{1'b0}};
            right_sh_r <= {DATA_SIZE{1'b0}};
        end else if (slot_start_s) begin
            if (ws_s == CH_LEFT) begin
                left_sh_r <= {DATA_SIZE{1'b0}};
            end else begin
                right_sh_r <= {DATA_SIZE{1'b0}};
            end
        end else if (cap_s) begin
            if (ws_s == CH_LEFT) begin
                left_sh_r <= left_next_s;
            end else begin
                right_sh_r <= right_next_s;
            end
        end
    end

    // Output pair register with valid/ready handshake and sticky overrun (set beats clear)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            left_data_r   <= {DATA_SIZE{1'b0}};
            right_data_r  <= {DATA_SIZE{1'b0}};
            frame_valid_r <= 1'b0;
            overrun_r     <= 1'b0;
        end else begin
            if (done_s && accept_s) begin
                left_data_r   <= left_sh_r;
                right_data_r  <= right_next_s;
                frame_valid_r <= 1'b1;
            end else if (frame_valid_r && frame_ready) begin
                frame_valid_r <= 1'b0;
            end
            if (drop_s) begin
                overrun_r <= 1'b1;
            end else if (overrun_clr) begin
                overrun_r <= 1'b0;
            end
        end
    end

`ifdef I2S_RX_OVERRUN_CNT_EN
    logic [OVERRUN_CNT_W-1:0] ovr_cnt_r;

    // Dropped-pair counter; a drop coinciding with clear leaves a count of one
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovr_cnt_r <= OVERRUN_CNT_W'(0);
        end else if (overrun_clr) begin
            ovr_cnt_r <= drop_s ? OVERRUN_CNT_W'(1) : OVERRUN_CNT_W'(0);
        end else if (drop_s) begin
            ovr_cnt_r <= sat_inc(ovr_cnt_r);
        end
    end

    assign overrun_count = ovr_cnt_r;
`endif

    assign i2s_sck     = sck_s;
    assign i2s_ws      = ws_s;
    assign left_data   = left_data_r;
    assign right_data  = right_data_r;
    assign frame_valid = frame_valid_r;
    assign overrun     = overrun_r;

endmodule

// File: tb/tb_i2s_rx_stereo.sv
// Randomized bench: a microphone model serialises frames, a pair-level model predicts outputs.
module tb_i2s_rx_stereo;

    localparam int DATA    = 24;
    localparam int SLOT    = 32;
    localparam int CLK_DIV = 2;
    localparam int FRAME   = 2 * SLOT;

    logic            clk;
    logic            rst_n;
    logic            enable;
    logic            i2s_sd;
    logic            i2s_sck;
    logic            i2s_ws;
    logic [DATA-1:0] left_data;
    logic [DATA-1:0] right_data;
    logic            frame_valid;
    logic            frame_ready;
    logic            overrun;
    logic            overrun_clr;
`ifdef I2S_RX_OVERRUN_CNT_EN
    logic [15:0]     overrun_count;
`endif

    i2s_rx_stereo #(
        .DATA_SIZE (DATA),
        .SLOT_SIZE (SLOT),
        .CLK_DIV   (CLK_DIV)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .i2s_sd        (i2s_sd),
        .i2s_sck       (i2s_sck),
        .i2s_ws        (i2s_ws),
        .left_data     (left_data),
        .right_data    (right_data),
        .frame_valid   (frame_valid),
        .frame_ready   (frame_ready),
        .overrun       (overrun),
`ifdef I2S_RX_OVERRUN_CNT_EN
        .overrun_count (overrun_count),
`endif
        .overrun_clr   (overrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks_r = 0;
    int errors_r = 0;

    // microphone state: bit index within the 64-bit frame and the words being sent
    int              idx_r = 0;
    bit              prev_sck_r = 1'b0;
    int              sck_cnt_r = 0;
    logic [DATA-1:0] cur_l_r = '0;
    logic [DATA-1:0] cur_r_r = '0;
    logic [47:0]     dir_q[$];

    // pair-level expectation
    bit              pend_r = 1'b0;
    logic [DATA-1:0] cand_l_r = '0;
    logic [DATA-1:0] cand_r_r = '0;
    logic [DATA-1:0] exp_l_r = '0;
    logic [DATA-1:0] exp_r_r = '0;
    bit              exp_valid_r = 1'b0;
    bit              exp_ovr_r = 1'b0;
    int              exp_cnt_r = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks_r++;
        if (got !== want) begin
            errors_r++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic load_frame();
        if (dir_q.size() > 0) begin
            {cur_l_r, cur_r_r} = dir_q.pop_front();
        end else begin
            cur_l_r = DATA'($urandom);
            cur_r_r = DATA'($urandom);
        end
    endtask

    // one clk: update the models for the edge just passed, drive SD, compare outputs
    task automatic tick();
        bit done;
        bit drop;
        int pos;
        @(negedge clk);
        if (!rst_n) begin
            exp_valid_r = 1'b0;
            exp_ovr_r   = 1'b0;
            exp_l_r     = '0;
            exp_r_r     = '0;
            exp_cnt_r   = 0;
        end else begin
            done = pend_r && enable;
            drop = 1'b0;
            if (done && (!exp_valid_r || frame_ready)) begin
                exp_l_r     = cand_l_r;
                exp_r_r     = cand_r_r;
                exp_valid_r = 1'b1;
            end else if (done) begin
                drop = 1'b1;
            end else if (exp_valid_r && frame_ready) begin
                exp_valid_r = 1'b0;
            end
            if (drop) exp_ovr_r = 1'b1;
            else if (overrun_clr) exp_ovr_r = 1'b0;
            if (overrun_clr) exp_cnt_r = drop ? 1 : 0;
            else if (drop && exp_cnt_r < 65535) exp_cnt_r++;
        end
        pend_r = 1'b0;

        if (!rst_n || !enable) begin
            check("sck_idle", i2s_sck, 1'b0);
            idx_r      = 0;
            prev_sck_r = 1'b0;
            sck_cnt_r  = 0;
        end else begin
            sck_cnt_r++;
            if (i2s_sck != prev_sck_r) begin
                check("sck_half_period", sck_cnt_r, CLK_DIV);
                sck_cnt_r = 0;
            end
            if (prev_sck_r && !i2s_sck) begin
                idx_r = (idx_r + 1) % FRAME;
                if (idx_r == 1) load_frame();
            end
            if (!prev_sck_r && i2s_sck && idx_r == SLOT + DATA) begin
                pend_r   = 1'b1;
                cand_l_r = cur_l_r;
                cand_r_r = cur_r_r;
            end
            prev_sck_r = i2s_sck;
        end

        pos = idx_r % SLOT;
        if (pos >= 1 && pos <= DATA) i2s_sd = (idx_r < SLOT) ? cur_l_r[DATA-pos] : cur_r_r[DATA-pos];
        else i2s_sd = 1'($urandom_range(0, 1));

        check("ws", i2s_ws, (idx_r >= SLOT));
        check("frame_valid", frame_valid, exp_valid_r);
        check("overrun", overrun, exp_ovr_r);
        check("left_data", left_data, exp_l_r);
        check("right_data", right_data, exp_r_r);
`ifdef I2S_RX_OVERRUN_CNT_EN
        check("overrun_count", overrun_count, exp_cnt_r);
`endif
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_valid(input int limit);
        int n = 0;
        while (!frame_valid && n < limit) begin
            tick();
            n++;
        end
        check("valid_wait", frame_valid, 1'b1);
    endtask

    task automatic run_until_idx(input int target, input int limit);
        int n = 0;
        while (idx_r != target && n < limit) begin
            tick();
            n++;
        end
        check("idx_wait", idx_r, target);
    endtask

    task automatic pulse_clr();
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
    endtask

    initial begin
        logic [DATA-1:0] race_l;
        int              n;
        rst_n       = 1'b0;
        enable      = 1'b0;
        frame_ready = 1'b0;
        overrun_clr = 1'b0;
        i2s_sd      = 1'b0;
        run(3);
        rst_n = 1'b1;
        run(2);

        // directed pair, consumer always ready
        dir_q.push_back({24'hA5A5A5, 24'h5A5A5A});
        frame_ready = 1'b1;
        enable      = 1'b1;
        wait_valid(600);
        check("dir_left", left_data, 24'hA5A5A5);
        check("dir_right", right_data, 24'h5A5A5A);
        tick();
        check("valid_one_clk", frame_valid, 1'b0);
        run(500);

        // consumer stalled across two frames: second pair dropped
        enable = 1'b0;
        run(4);
        pulse_clr();
        dir_q.push_back({24'h000001, 24'h123456});
        dir_q.push_back({24'h7FFFFF, 24'h654321});
        frame_ready = 1'b0;
        enable      = 1'b1;
        run(560);
        check("ovr_hold_left", left_data, 24'h000001);
        check("ovr_hold_right", right_data, 24'h123456);
        check("ovr_set", overrun, 1'b1);
        pulse_clr();
        check("ovr_clr", overrun, 1'b0);
        frame_ready = 1'b1;
        run(300);

        // ready rises exactly in the completion clk of a new pair
        frame_ready = 1'b0;
        pulse_clr();
        n = 0;
        while (!(pend_r && frame_valid) && n < 1200) begin
            tick();
            n++;
        end
        check("race_wait", pend_r && frame_valid, 1'b1);
        race_l      = cand_l_r;
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        check("race_valid", frame_valid, 1'b1);
        check("race_left", left_data, race_l);
        check("race_ovr", overrun, 1'b0);
        frame_ready = 1'b1;
        run(20);

        // enable dropped mid-left-slot, then resumed
        run_until_idx(10, 600);
        enable = 1'b0;
        run(40);
        check("off_ws", i2s_ws, 1'b0);
        dir_q.push_back({24'h3C3C3C, 24'hC3C3C3});
        enable = 1'b1;
        wait_valid(700);
        check("resume_left", left_data, 24'h3C3C3C);
        check("resume_right", right_data, 24'hC3C3C3);

        // random backpressure and clears
        for (int i = 0; i < 2048; i++) begin
            frame_ready = ($urandom_range(0, 3) != 0);
            overrun_clr = ($urandom_range(0, 63) == 0);
            tick();
        end

        // three dropped pairs, then reset mid-right-slot
        frame_ready = 1'b1;
        overrun_clr = 1'b0;
        enable      = 1'b0;
        run(4);
        pulse_clr();
        frame_ready = 1'b0;
        enable      = 1'b1;
        run(1024);
        check("drop_ovr", overrun, 1'b1);
`ifdef I2S_RX_OVERRUN_CNT_EN
        check("drop_cnt3", overrun_count, 16'd3);
`endif
        run_until_idx(40, 600);
        rst_n = 1'b0;
        tick();
        check("rst_valid", frame_valid, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        check("rst_left", left_data, 24'h0);
        check("rst_sck", i2s_sck, 1'b0);
`ifdef I2S_RX_OVERRUN_CNT_EN
        check("rst_cnt", overrun_count, 16'd0);
`endif
        rst_n       = 1'b1;
        frame_ready = 1'b1;
        run(300);

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule

// File: doc/i2s_rx_stereo.md
Name: i2s_rx_stereo

Overview:
- Parametrised stereo I2S master receiver for the microphone front-end.
- Generates SCK and WS from clk with an integer divider.
- Captures left and right slots with standard I2S one-bit delay.
- Presents each complete stereo pair on a valid/ready output with sticky overrun detection; feeds the downstream audio buffer/filter chain.

Parameters:
- DATA_SIZE, 24: captured bits per channel; 1 <= DATA_SIZE <= SLOT_SIZE-1.
- SLOT_SIZE, 32: SCK cycles per channel slot; WS period = 2*SLOT_SIZE SCK cycles.
- CLK_DIV, 4: clk cycles per SCK half-period, >= 1; SCK = clk / (2*CLK_DIV).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- enable  in  1  run interface; low = idle.
- i2s_sd  in  1  serial data from microphone(s).
- i2s_sck  out  1  bit clock to microphone.
- i2s_ws  out  1  word select; 0 = left, 1 = right.
- left_data  out  DATA_SIZE  left sample, two's complement, MSB-first assembled.
- right_data  out  DATA_SIZE  right sample.
- frame_valid  out  1  stereo pair available.
- frame_ready  in  1  consumer accepts pair.
- overrun  out  1  sticky: a completed pair was dropped.
- overrun_clr  in  1  clears overrun.

Behaviour:
- Reset: i2s_sck=0, i2s_ws=0, left_data=0, right_data=0, frame_valid=0, overrun=0; divider, bit position and shift registers cleared.
- Divider counts 0..CLK_DIV-1; on wrap, toggle SCK. This produces single-clk strobes sck_rise (0->1) and sck_fall (1->0) in the same clk cycle the registered SCK changes.
- Slot position pos (0..SLOT_SIZE-1) advances on sck_fall. On wrap SLOT_SIZE-1 -> 0, WS toggles in the same cycle.
- Capture on sck_rise: i2s_sd is shifted into the active channel's shift register when 1 <= pos <= DATA_SIZE. pos 0 is the I2S delay bit; positions > DATA_SIZE are ignored.
- On the sck_rise sampling right-slot pos == DATA_SIZE, the pair is complete. In the next clk, left_data/right_data load from the shift registers and frame_valid=1.
- Latency: frame_valid asserts exactly 1 clk after the right-channel LSB sample.
- Handshake: a transfer occurs when frame_valid && frame_ready. If nothing new completes, frame_valid drops the next clk. Outputs are stable while valid && !ready.
- Overrun: if a pair completes while frame_valid && !frame_ready, the new pair is discarded, outputs are held, and overrun=1.
- Simultaneous completion and transfer: the new pair loads, frame_valid stays 1, no overrun.
- overrun_clr takes effect the next clk. If it coincides with a new overrun, the set wins.
- Startup: after reset or enable rising, the interface starts at left slot pos 0 with SCK=0 and WS=0. The first pair presented is the first fully captured left+right pair.
- enable low (including mid-frame): next clk, SCK=0, WS=0, divider/pos/shift registers cleared, partial pair discarded. Output registers, frame_valid and overrun are held, and the handshake still works.
- Reset mid-frame: all state returns to reset values; no partial pair is ever emitted.

Optional Feature:
- Macro I2S_RX_OVERRUN_CNT_EN.
- Defined: adds output overrun_count [15:0]. It increments (saturating at 16'hFFFF) on each dropped pair, is cleared by rst_n and by overrun_clr, and if increment and clear coincide the result is 1.
- Undefined: port and counter absent; the overrun flag alone remains.

Decomposition:
- Package i2s_pkg: typedef enum logic {CH_LEFT=1'b0, CH_RIGHT=1'b1} i2s_ch_e; localparam defaults I2S_DATA_SIZE=24, I2S_SLOT_SIZE=32; OVERRUN_CNT_W=16.
- Sub-module i2s_clkgen (params CLK_DIV, SLOT_SIZE): outputs sck, ws, sck_rise, sck_fall and pos. It honours rst_n/enable identically.

Test Plan:
- CLK_DIV=2, SLOT_SIZE=32, enable=1 -> SCK period 4 clk, WS period 256 clk, WS edges coincident with SCK falling edges.
- Drive left 24'hA5A5A5, right 24'h5A5A5A (MSB at pos 1, trailing slot bits 1), frame_ready=1 -> left_data=A5A5A5, right_data=5A5A5A, frame_valid high 1 clk, 1 clk after the right LSB sample.
- frame_ready=0 across two frames (24'h000001 then 24'h7FFFFF) -> outputs stay 000001, overrun=1; overrun_clr pulse -> overrun=0 next clk.
- Assert frame_ready exactly in the clk a new pair completes -> new pair loaded, frame_valid stays 1, overrun stays 0.
- Deassert enable mid-left-slot, re-enable -> SCK/WS idle at 0 while off; first emitted pair matches only post-enable stimulus.
- rst_n low mid-right-slot -> all outputs 0 next clk; with I2S_RX_OVERRUN_CNT_EN, 3 dropped pairs -> overrun_count=3, then reset -> 0.
